trigger_hit_sched: RTL

Per-bunch-crossing hit scheduler between the 12-channel trigger front-end and the TCM readout path.
- Once per BC (8 clk320 cycles, phase given by mt_cou), snapshots the channel trigger flags with each channel's time and amplitude.
- Emits one channel record per cycle over a valid/ready stream, with round-robin priority rotated each BC.
- Raises tcm_req and reports hit multiplicity.
- Counts records lost when a BC's hits cannot all be drained before the next snapshot.

---
 rtl/trigger_hit_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/trigger_hit_sched.sv
// Per-bunch-crossing hit scheduler: snapshots channel triggers once per BC
// and streams one channel record per cycle with rotating round-robin priority.
module trigger_hit_sched #(
  parameter int unsigned N_CH       = 12,
  parameter int unsigned TW         = 10,
  parameter int unsigned AW         = 13,
  parameter int unsigned SNAP_PHASE = 0,
  parameter int unsigned DW         = 16
) (
  input  logic                 clk320,
  input  logic                 rstn,
  input  logic [2:0]           mt_cou,
  input  logic                 en,
  input  logic [N_CH-1:0]      ch_trig,
  input  logic [N_CH*TW-1:0]   ch_time,
  input  logic [N_CH*AW-1:0]   ch_ampl,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [3:0]           out_ch,
  output logic [TW-1:0]        out_time,
  output logic [AW-1:0]        out_ampl,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 tcm_req,
  output logic [3:0]           hit_cnt,
  output logic [DW-1:0]        drop_cnt,
  output logic                 busy
);

  localparam int unsigned CHW = 4;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [CHW-1:0]      rr_q, rr_d;
  logic [N_CH*TW-1:0]  time_q, time_d;
  logic [N_CH*AW-1:0]  ampl_q, ampl_d;

  logic                out_valid_d, out_first_d, out_last_d, tcm_req_d, busy_d;
  logic [CHW-1:0]      out_ch_d;
  logic [TW-1:0]       out_time_d;
  logic [AW-1:0]       out_ampl_d;
  logic [3:0]          hit_cnt_d;
  logic [DW-1:0]       drop_cnt_d;

  logic                snap_c;
  logic                accept_c;
  logic [N_CH-1:0]     pend_after;
  logic [N_CH-1:0]     upper;
  logic [N_CH-1:0]     sel_oh;
  logic [N_CH*TW-1:0]  tsrc;
  logic [N_CH*AW-1:0]  asrc;
  logic [DW:0]         dsum;

  function automatic logic [3:0] popc(input logic [N_CH-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < int'(N_CH); i++) c = c + 4'(m[i]);
    return c;
  endfunction

  // State and output registers
  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      time_q    <= '0;
      ampl_q    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_time  <= '0;
      out_ampl  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      tcm_req   <= 1'b0;
      hit_cnt   <= '0;
      drop_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      time_q    <= time_d;
      ampl_q    <= ampl_d;
      out_valid <= out_valid_d;
      out_ch    <= out_ch_d;
      out_time  <= out_time_d;
      out_ampl  <= out_ampl_d;
      out_first <= out_first_d;
      out_last  <= out_last_d;
      tcm_req   <= tcm_req_d;
      hit_cnt   <= hit_cnt_d;
      drop_cnt  <= drop_cnt_d;
      busy      <= busy_d;
    end
  end

  // Next-state: snapshot/drain of the pending mask, selection and flags
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rr_d        = rr_q;
    time_d      = time_q;
    ampl_d      = ampl_q;
    out_ch_d    = '0;
    out_time_d  = '0;
    out_ampl_d  = '0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_valid_d = 1'b0;
    tcm_req_d   = 1'b0;
    hit_cnt_d   = hit_cnt;
    drop_cnt_d  = drop_cnt;
    busy_d      = 1'b0;
    upper       = '0;
    sel_oh      = '0;
    dsum        = '0;

    snap_c   = (mt_cou == 3'(SNAP_PHASE));
    accept_c = out_valid & out_ready;

    // remove the record accepted this cycle
    pend_after = pending_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (accept_c && (out_ch == CHW'(i))) pend_after[i] = 1'b0;
    end

    tsrc = time_q;
    asrc = ampl_q;
    if (snap_c) begin
      pending_d = ch_trig & {N_CH{en}};
      rr_d      = (rr_q == CHW'(N_CH - 1)) ? '0 : rr_q + CHW'(1);
      time_d    = ch_time;
      ampl_d    = ch_ampl;
      tsrc      = ch_time;
      asrc      = ch_ampl;
      hit_cnt_d = popc(pending_d);
      tcm_req_d = (pending_d != '0);
      // anything still pending here (held record included) is lost
      dsum       = {1'b0, drop_cnt} + (DW+1)'(popc(pend_after));
      drop_cnt_d = dsum[DW] ? {DW{1'b1}} : dsum[DW-1:0];
    end else begin
      pending_d = pend_after;
    end

    // round-robin pick: lowest set bit at or above rr_d, else lowest overall
    for (int i = 0; i < int'(N_CH); i++) begin
      upper[i] = pending_d[i] && (CHW'(i) >= rr_d);
    end
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (upper != '0) begin
        if (upper[i]) out_ch_d = CHW'(i);
      end else if (pending_d[i]) begin
        out_ch_d = CHW'(i);
      end
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      if (out_ch_d == CHW'(i)) begin
        sel_oh[i]  = 1'b1;
        out_time_d = tsrc[i*TW +: TW];
        out_ampl_d = asrc[i*AW +: AW];
      end
    end

    case (state_q)
      IDLE:    if (pending_d != '0) state_d = EMIT;
      EMIT:    if (pending_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == EMIT);
    busy_d      = (pending_d != '0);
    out_last_d  = out_valid_d && ((pending_d & ~sel_oh) == '0);
    if (snap_c)        out_first_d = out_valid_d;
    else if (accept_c) out_first_d = 1'b0;
    else               out_first_d = out_first & out_valid_d;
    if (!out_valid_d) out_ch_d = '0;
  end

endmodule
